// File: rtl/ma_split_unit_pkg.sv
// ma_split_unit_pkg: access-length codes, FSM state encodings and size helper for ma_split_unit.
package ma_split_unit_pkg;
   localparam logic [1:0] MA_LEN_1B = 2'd0;
   localparam logic [1:0] MA_LEN_2B = 2'd1;
   localparam logic [1:0] MA_LEN_4B = 2'd2;
   typedef enum logic [1:0] {
      MA_ST_IDLE  = 2'd0,
      MA_ST_BEAT1 = 2'd1,
      MA_ST_BEAT2 = 2'd2,
      MA_ST_RESP  = 2'd3
   } ma_state_e;
   function automatic logic [2:0] ma_size(input logic [1:0] len);
      return len == MA_LEN_1B ? 3'd1 : len == MA_LEN_2B ? 3'd2 : 3'd4;
   endfunction
endpackage

// File: rtl/ma_split_unit_lane_align.sv
// ma_lane_align: store lane shifter, byte-enable generation, load merge and sign/zero extension.
module ma_lane_align
   import ma_split_unit_pkg::*;
#(
   parameter int BUS_W = 32,
   localparam int BB = BUS_W / 8,
   localparam int OW = $clog2(BB)
) (
   input  logic [OW-1:0]    off,
   input  logic [1:0]       len,
   input  logic             uns,
   input  logic             beat2,
   input  logic [31:0]      wdata,
   input  logic [BUS_W-1:0] mem_rdata,
   input  logic [31:0]      buf_q,
   output logic [BUS_W-1:0] lane_wdata,
   output logic [BB-1:0]    lane_be,
   output logic [31:0]      buf_merged,
   output logic [31:0]      ext_data
);
   logic [2*BUS_W-1:0] wide_w;
   logic [2*BB-1:0]    wide_be;
   logic [3:0]         mask;
   // The upper half of the double-width shift is exactly what the second beat carries.
   always_comb begin
      mask = len == MA_LEN_1B ? 4'h1 : len == MA_LEN_2B ? 4'h3 : 4'hF;
      wide_w = (2*BUS_W)'(wdata) << (int'(off) * 8);
      wide_be = (2*BB)'(mask) << off;
      lane_wdata = beat2 ? wide_w[2*BUS_W-1:BUS_W] : wide_w[BUS_W-1:0];
      lane_be = beat2 ? wide_be[2*BB-1:BB] : wide_be[BB-1:0];
      buf_merged = beat2 ? buf_q | 32'(mem_rdata << ((BB - int'(off)) * 8))
                         : 32'(mem_rdata >> (int'(off) * 8));
      ext_data = len == MA_LEN_1B ? {{24{~uns & buf_q[7]}}, buf_q[7:0]}
               : len == MA_LEN_2B ? {{16{~uns & buf_q[15]}}, buf_q[15:0]} : buf_q;
   end
endmodule

// File: rtl/ma_split_unit.sv
// ma_split_unit: MEM-stage data access controller splitting bus-crossing accesses into two beats.
// Define MA_TRAP_EN to trap split accesses (misaligned_err) instead of performing two beats.
module ma_split_unit
   import ma_split_unit_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int BUS_W = 32,
   parameter int DATA_W = 32,
   localparam int BUS_BYTES = BUS_W / 8,
   localparam int OW = $clog2(BUS_BYTES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req,
   input  logic                 store,
   input  logic [1:0]           len,
   input  logic                 uns,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [DATA_W-1:0]    wdata,
   output logic [DATA_W-1:0]    rdata,
   output logic                 done,
   output logic                 stall,
   output logic                 misaligned_err,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [BUS_BYTES-1:0] mem_be,
   output logic [BUS_W-1:0]     mem_wdata,
   input  logic                 mem_ack,
   input  logic [BUS_W-1:0]     mem_rdata
);
   ma_state_e            state_q, state_d;
   logic [DATA_W-1:0]    buf_q, buf_d, buf_merged, ext_data;
   logic [OW-1:0]        off;
   logic [ADDR_W-1:0]    base;
   logic [BUS_W-1:0]     lane_wdata;
   logic [BUS_BYTES-1:0] lane_be;
   logic                 split, bad_len, trap, beat, beat2;

   ma_lane_align #(.BUS_W(BUS_W)) u_align (
      .off(off), .len(len), .uns(uns), .beat2(beat2), .wdata(wdata),
      .mem_rdata(mem_rdata), .buf_q(buf_q), .lane_wdata(lane_wdata),
      .lane_be(lane_be), .buf_merged(buf_merged), .ext_data(ext_data)
   );

   always_comb begin
      off = addr[OW-1:0];
      base = addr & ~ADDR_W'(BUS_BYTES - 1);
      bad_len = len == 2'd3;
      split = (int'(off) + int'(ma_size(len))) > BUS_BYTES;
`ifdef MA_TRAP_EN
      trap = split & ~bad_len;
`else
      trap = 1'b0;
`endif
      beat2 = state_q == MA_ST_BEAT2;
      beat = beat2 | (state_q == MA_ST_BEAT1);
      mem_req = beat;
      mem_we = beat & store;
      mem_addr = beat2 ? base + ADDR_W'(BUS_BYTES) : base;
      mem_be = (beat & store) ? lane_be : '0;
      mem_wdata = beat ? lane_wdata : '0;
      done = state_q == MA_ST_RESP;
      misaligned_err = done & trap;
      rdata = (done & ~store & ~bad_len & ~trap) ? ext_data : '0;
      stall = req & ~done;
   end

   always_comb begin
      state_d = state_q;
      buf_d = buf_q;
      unique case (state_q)
         MA_ST_IDLE:  if (req) state_d = (bad_len | trap) ? MA_ST_RESP : MA_ST_BEAT1;
         MA_ST_BEAT1: if (mem_ack) begin
            buf_d = buf_merged;
            state_d = split ? MA_ST_BEAT2 : MA_ST_RESP;
         end
         MA_ST_BEAT2: if (mem_ack) begin
            buf_d = buf_merged;
            state_d = MA_ST_RESP;
         end
         default:     state_d = MA_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MA_ST_IDLE;
         buf_q <= '0;
      end else begin
         state_q <= state_d;
         buf_q <= buf_d;
      end
   end
endmodule
